// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle multiply/divide unit that owns the architectural HI/LO pair.
//   A start pulse computes the full 64-bit result immediately into pending
//   registers. busy is then held for a fixed latency, and the result is
//   committed to HI/LO on the final edge. clear_xalu aborts an in-flight
//   operation. mthi/mtlo writes go through we/hilo.
//
//   Optional build macro: MULDIV_EARLY_BUSY_EN
//     defined   : busy also asserts combinationally in the start cycle
//     undefined : busy is purely registered (rises after the start edge)
//
// Ports
//   clk         in   1  rising-edge clock
//   rst         in   1  asynchronous active-high reset
//   D1          in  32  rs: dividend / multiplicand / mthi-mtlo data
//   D2          in  32  rt: divisor / multiplier
//   op          in   2  00 mult, 01 multu, 10 div, 11 divu
//   start       in   1  launch op this cycle
//   we          in   1  mthi/mtlo write this cycle
//   hilo        in   1  write target: 1 HI, 0 LO
//   interupt    in   1  exception taken; request in E is flushed
//   clear_xalu  in   1  abort any in-flight operation
//   HI, LO      out 32  architectural HI/LO
//   busy        out  1  operation in flight
//
// States
//   S_IDLE | no operation in flight; accepts start / we
//   S_RUN  | counting down latency; commits pending result at terminal count
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic [1:0]  op,
  input  logic        start,
  input  logic        we,
  input  logic        hilo,
  input  logic        interupt,
  input  logic        clear_xalu,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [31:0]   r_pend_hi;
  logic [31:0]   r_pend_lo;

  // ------------------------------------------------------------------
  // Arithmetic
  // ------------------------------------------------------------------
  logic [63:0] w_mul_s;
  logic [63:0] w_mul_u;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_abs;
  logic [31:0] w_b_abs;
  logic [31:0] w_sden;
  logic [31:0] w_uden;
  logic [31:0] w_q_abs;
  logic [31:0] w_r_abs;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic        w_dz;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  // Low 64 bits of the product of sign-extended operands is the signed product.
  assign w_mul_s = {{32{D1[31]}}, D1} * {{32{D2[31]}}, D2};
  assign w_mul_u = {32'd0, D1} * {32'd0, D2};

  assign w_dz    = (D2 == 32'd0);
  assign w_a_neg = D1[31];
  assign w_b_neg = D2[31];
  assign w_a_abs = w_a_neg ? (32'd0 - D1) : D1;
  assign w_b_abs = w_b_neg ? (32'd0 - D2) : D2;

  // Substitute 1 for a zero divisor so the dividers never see /0; the
  // divide-by-zero result is selected separately below.
  assign w_sden  = w_dz ? 32'd1 : w_b_abs;
  assign w_uden  = w_dz ? 32'd1 : D2;

  assign w_q_abs = w_a_abs / w_sden;
  assign w_r_abs = w_a_abs % w_sden;

  // Magnitude division then sign fix-up: truncation toward zero, remainder
  // follows the dividend. 0x80000000 / -1 falls out naturally as
  // q = 0x80000000, r = 0, since negating 0x80000000 wraps to itself.
  assign w_sq = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_abs) : w_q_abs;
  assign w_sr = w_a_neg ? (32'd0 - w_r_abs) : w_r_abs;
  assign w_uq = D1 / w_uden;
  assign w_ur = D1 % w_uden;

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    case (op)
      2'b00: begin
        w_res_hi = w_mul_s[63:32];
        w_res_lo = w_mul_s[31:0];
      end
      2'b01: begin
        w_res_hi = w_mul_u[63:32];
        w_res_lo = w_mul_u[31:0];
      end
      2'b10: begin
        w_res_hi = w_dz ? D1 : w_sr;
        w_res_lo = w_dz ? 32'hFFFF_FFFF : w_sq;
      end
      default: begin
        w_res_hi = w_dz ? D1 : w_ur;
        w_res_lo = w_dz ? 32'hFFFF_FFFF : w_uq;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ------------------------------------------------------------------
  // FSM: next state
  // ------------------------------------------------------------------
  logic w_last;
  assign w_last = (r_cnt == CW'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start && !interupt && !clear_xalu) w_state_nxt = S_RUN;
      S_RUN:  if (clear_xalu || w_last)              w_state_nxt = S_IDLE;
      default:                                       w_state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: control outputs
  // ------------------------------------------------------------------
  logic w_launch;
  logic w_commit;
  logic w_abort;
  logic w_wr;
  logic w_busy_reg;

  always_comb begin
    w_launch   = 1'b0;
    w_commit   = 1'b0;
    w_abort    = 1'b0;
    w_wr       = 1'b0;
    w_busy_reg = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_launch = start && !interupt && !clear_xalu;
        // start (even when suppressed) always shadows a same-cycle we.
        w_wr     = we && !start && !interupt;
      end
      S_RUN: begin
        w_busy_reg = 1'b1;
        w_abort    = clear_xalu;
        w_commit   = !clear_xalu && w_last;
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
    end else if (w_launch) begin
      r_cnt     <= op[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
      r_pend_hi <= w_res_hi;
      r_pend_lo <= w_res_lo;
    end else if (w_abort) begin
      r_cnt     <= '0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
    end else if (w_busy_reg) begin
      r_cnt     <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_commit) begin
      r_hi <= r_pend_hi;
      r_lo <= r_pend_lo;
    end else if (w_wr) begin
      if (hilo) r_hi <= D1;
      else      r_lo <= D1;
    end
  end

  assign HI = r_hi;
  assign LO = r_lo;

`ifdef MULDIV_EARLY_BUSY_EN
  assign busy = w_busy_reg | (start & ~interupt & ~clear_xalu);
`else
  assign busy = w_busy_reg;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] D1, D2;
  logic [1:0]  op;
  logic        start, we, hilo, interupt, clear_xalu;
  logic [31:0] HI, LO;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  muldiv_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .D1(D1), .D2(D2), .op(op), .start(start),
    .we(we), .hilo(hilo), .interupt(interupt), .clear_xalu(clear_xalu),
    .HI(HI), .LO(LO), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one cycle; checks the start-cycle busy value for the build.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; D1 = a; D2 = b; start = 1'b1;
    #1;
`ifdef MULDIV_EARLY_BUSY_EN
    chk("start_cycle_busy", {31'd0, busy}, 32'd1);
`else
    chk("start_cycle_busy", {31'd0, busy}, 32'd0);
`endif
    step();
    start = 1'b0;
  endtask

  // Wait for busy to drop; HI/LO must hold until the commit edge.
  task automatic wait_done(input string tag, input int exp_cyc);
    int n;
    logic [31:0] hi0, lo0;
    n = 0; hi0 = HI; lo0 = LO;
    while (busy && n < 40) begin
      if (HI !== hi0 || LO !== lo0) begin
        chk({tag, "_hold_hi"}, HI, hi0);
        chk({tag, "_hold_lo"}, LO, lo0);
      end
      step();
      n++;
    end
    chk({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    launch(o, a, b);
    wait_done(tag, o[1] ? 10 : 5);
    chk({tag, "_hi"}, HI, ehi);
    chk({tag, "_lo"}, LO, elo);
  endtask

  task automatic write_hl(input logic h, input logic [31:0] d);
    we = 1'b1; hilo = h; D1 = d;
    step();
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; D1 = '0; D2 = '0; op = '0; start = 0; we = 0; hilo = 0;
    interupt = 0; clear_xalu = 0;
    #12;
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    step();
    rst = 1'b0;
    step();

    run_op("mult_neg2x3", 2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("divu_100_7",  2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2",    2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_op("div_5_0",     2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_op("div_m5_0",    2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("divu_9_0",    2'b11, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);
    run_op("div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_min2",   2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("divu_big",    2'b11, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC);

    // mthi, then abort a multu in its 3rd busy cycle.
    write_hl(1'b1, 32'h11);
    chk("mthi_hi", HI, 32'h11);
    chk("mthi_lo", LO, 32'h7FFF_FFFC);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    launch(2'b01, 32'd4, 32'd4);
    step(); step();
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    clear_xalu = 1'b1;
    step();
    clear_xalu = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", HI, 32'h11);
    chk("abort_lo", LO, 32'h7FFF_FFFC);
    repeat (6) step();
    chk("abort_no_late_hi", HI, 32'h11);
    chk("abort_no_late_lo", LO, 32'h7FFF_FFFC);
    write_hl(1'b0, 32'hABCD);
    chk("mtlo_lo", LO, 32'hABCD);
    chk("mtlo_hi", HI, 32'h11);

    // Abort coinciding with the would-be commit edge.
    launch(2'b00, 32'd2, 32'd3);
    repeat (4) step();
    chk("late_abort_busy_before", {31'd0, busy}, 32'd1);
    clear_xalu = 1'b1;
    step();
    clear_xalu = 1'b0;
    chk("late_abort_busy", {31'd0, busy}, 32'd0);
    chk("late_abort_hi", HI, 32'h11);
    chk("late_abort_lo", LO, 32'hABCD);

    // Requests suppressed by an exception.
    interupt = 1'b1; start = 1'b1; op = 2'b00; D1 = 32'd7; D2 = 32'd7;
    #1;
    chk("int_start_busy_comb", {31'd0, busy}, 32'd0);
    step();
    start = 1'b0;
    chk("int_start_busy", {31'd0, busy}, 32'd0);
    we = 1'b1; hilo = 1'b1; D1 = 32'hDEAD;
    step();
    we = 1'b0; interupt = 1'b0;
    chk("int_we_hi", HI, 32'h11);
    chk("int_we_lo", LO, 32'hABCD);
    repeat (6) step();
    chk("int_no_commit_lo", LO, 32'hABCD);

    // clear_xalu with start in IDLE: no launch.
    clear_xalu = 1'b1; start = 1'b1; op = 2'b01; D1 = 32'd3; D2 = 32'd3;
    #1;
    chk("clr_start_busy_comb", {31'd0, busy}, 32'd0);
    step();
    start = 1'b0; clear_xalu = 1'b0;
    chk("clr_start_busy", {31'd0, busy}, 32'd0);
    repeat (6) step();
    chk("clr_start_lo", LO, 32'hABCD);

    // start and we together: start wins, we ignored.
    we = 1'b1; hilo = 1'b1;
    launch(2'b00, 32'd2, 32'd3);
    we = 1'b0;
    chk("start_we_hi_kept", HI, 32'h11);
    wait_done("start_we", 5);
    chk("start_we_hi", HI, 32'd0);
    chk("start_we_lo", LO, 32'd6);

    // Async reset in the middle of a run.
    write_hl(1'b1, 32'h55);
    launch(2'b10, 32'd100, 32'd7);
    step(); step();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_hi", HI, 32'd0);
    chk("rst_mid_lo", LO, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    step();
    rst = 1'b0;
    repeat (12) step();
    chk("rst_after_busy", {31'd0, busy}, 32'd0);
    chk("rst_after_hi", HI, 32'd0);
    chk("rst_after_lo", LO, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
